// File: rtl/laser_shot.sv
// Hunter laser controller: latches the shot column on a fire press, streams the
// laser pixels, scores bird hits, then holds, erases and cools down before re-arming.
module laser_shot #(
    parameter logic [6:0] HUNTER_Y     = 7'd112,
    parameter logic [3:0] LASER_FRAMES = 4'd6,
    parameter logic [5:0] COOL_FRAMES  = 6'd30,
    parameter logic [2:0] LASER_COLOUR = 3'b010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_frame,
    input  logic        fire,
    input  logic [7:0]  hunter_x,
    input  logic [55:0] bird_x,
    input  logic [48:0] bird_y,
    input  logic [6:0]  bird_on,
    input  logic        grant,
    output logic        req,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  colour,
    output logic [6:0]  kill,
    output logic [7:0]  score,
    output logic        busy
);

    // Pixel handshake: a pixel is offered while req=1 and is consumed on any
    // cycle where grant=1; with grant=0 the pixel outputs hold. grant is
    // ignored whenever req=0.

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_HIT_CHECK,
        S_HOLD,
        S_ERASE,
        S_COOLDOWN
    } state_t;

    localparam logic [6:0] Y_TOP      = HUNTER_Y - 7'd1;
    localparam logic [5:0] LASER_LAST = {2'b00, LASER_FRAMES} - 6'd1;
    localparam logic [5:0] COOL_LAST  = COOL_FRAMES - 6'd1;

    state_t      state_q, state_d;
    logic        fire_d_q, fire_d_d;
    logic [7:0]  shot_x_q, shot_x_d;
    logic [6:0]  y_q, y_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  score_q, score_d;

    logic        press;
    logic [6:0]  hit;
    logic [7:0]  diff [7];
    logic [3:0]  hit_cnt;
    logic [8:0]  score_sum;

    assign press = fire & ~fire_d_q;

    // Column distance is taken mod 256 so a bird just right of the laser near
    // the screen edge still wraps correctly.
    always_comb begin
        hit     = '0;
        hit_cnt = '0;
        for (int i = 0; i < 7; i++) begin
            diff[i] = bird_x[8*i +: 8] - shot_x_q;
            hit[i]  = bird_on[i] && (diff[i] <= 8'd5) && (bird_y[7*i +: 7] < HUNTER_Y);
            hit_cnt = hit_cnt + {3'b000, hit[i]};
        end
        score_sum = {1'b0, score_q} + {5'b00000, hit_cnt};
    end

    always_comb begin
        state_d  = state_q;
        fire_d_d = fire;
        shot_x_d = shot_x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        score_d  = score_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d  = S_DRAW;
                    shot_x_d = hunter_x;
                    y_d      = Y_TOP;
                end
            end
            S_DRAW: begin
                if (grant) begin
                    if (y_q == 7'd0) begin
                        state_d = S_HIT_CHECK;
                    end else begin
                        y_d = y_q - 7'd1;
                    end
                end
            end
            S_HIT_CHECK: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                score_d = score_sum[8] ? 8'hff : score_sum[7:0];
            end
            S_HOLD: begin
                if (one_frame) begin
                    if (cnt_q == LASER_LAST) begin
                        state_d = S_ERASE;
                        y_d     = Y_TOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_ERASE: begin
                if (grant) begin
                    if (y_q == 7'd0) begin
                        state_d = S_COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        y_d = y_q - 7'd1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (one_frame) begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // fire_d resets high so a button held through reset cannot fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fire_d_q <= 1'b1;
            shot_x_q <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            fire_d_q <= fire_d_d;
            shot_x_q <= shot_x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
        end
    end

    assign req    = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign x_out  = shot_x_q;
    assign y_out  = y_q;
    assign colour = (state_q == S_DRAW) ? LASER_COLOUR : 3'b000;
    assign kill   = (state_q == S_HIT_CHECK) ? hit : 7'b0000000;
    assign score  = score_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_laser_shot.sv
// Self-checking bench for laser_shot: table of hit-check shots plus hand-written
// sequences for grant stalls, score saturation and reset mid-shot.
module tb_laser_shot;
  localparam int HY = 112;
  localparam int LF = 6;
  localparam int CF = 30;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_frame;
  logic        fire;
  logic [7:0]  hunter_x;
  logic [55:0] bird_x;
  logic [48:0] bird_y;
  logic [6:0]  bird_on;
  logic        grant;
  logic        req;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic [6:0]  kill;
  logic [7:0]  score;
  logic        busy;

  laser_shot dut (
    .clock(clock), .reset(reset), .one_frame(one_frame), .fire(fire),
    .hunter_x(hunter_x), .bird_x(bird_x), .bird_y(bird_y), .bird_on(bird_on),
    .grant(grant), .req(req), .x_out(x_out), .y_out(y_out), .colour(colour),
    .kill(kill), .score(score), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_score = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_fire();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      one_frame = 1'b1;
      tick();
      one_frame = 1'b0;
      tick();
    end
  endtask

  // Pushes the whole expected column, then pops one entry per granted cycle.
  // Final bird inputs are applied just before the last grant so only the
  // HIT_CHECK sample matters.
  task automatic stream(input logic [7:0] sx, input logic [2:0] col, input bit toggle,
                        input logic [55:0] bx, input logic [48:0] by, input logic [6:0] bon);
    int budget;
    bit g;
    logic [17:0] e;
    budget = 1000;
    g = 1'b1;
    for (int y = HY - 1; y >= 0; y--) begin
      e = {sx, y[6:0], col};
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0 && budget > 0) begin
      if (exp_q.size() == 1) begin
        bird_x = bx; bird_y = by; bird_on = bon;
      end
      grant = toggle ? g : 1'b1;
      g = ~g;
      check("stream_req", int'(req), 1);
      check("stream_kill", int'(kill), 0);
      check("stream_pixel", int'({x_out, y_out, colour}), int'(exp_q[0]));
      if (grant) e = exp_q.pop_front();
      tick();
      budget--;
    end
    grant = 1'b0;
    if (budget == 0) begin
      check("stream_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic run_shot(input logic [7:0] hx, input logic [55:0] bx, input logic [48:0] by,
                          input logic [6:0] bon, input logic [6:0] exp_kill, input bit toggle);
    int s;
    bird_x = {$urandom, $urandom};
    bird_y = {$urandom, $urandom};
    bird_on = 7'h7f;
    hunter_x = hx;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    hunter_x = ~hx;
    check("draw_busy", int'(busy), 1);
    stream(hx, 3'b010, toggle, bx, by, bon);
    check("hit_req", int'(req), 0);
    check("hit_kill", int'(kill), int'(exp_kill));
    s = exp_score + $countones(exp_kill);
    exp_score = (s > 255) ? 255 : s;
    tick();
    check("hold_kill", int'(kill), 0);
    check("score", int'(score), exp_score);
    press_fire();
    pulse_frames(LF - 1);
    check("hold_req", int'(req), 0);
    check("hold_busy", int'(busy), 1);
    one_frame = 1'b1;
    tick();
    one_frame = 1'b0;
    check("erase_start_y", int'(y_out), HY - 1);
    stream(hx, 3'b000, 1'b0, bx, by, bon);
    check("cool_req", int'(req), 0);
    press_fire();
    pulse_frames(CF - 1);
    press_fire();
    check("cool_busy", int'(busy), 1);
    check("cool_req2", int'(req), 0);
    one_frame = 1'b1;
    tick();
    one_frame = 1'b0;
    check("idle_busy", int'(busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  hx;
    logic [55:0] bx;
    logic [48:0] by;
    logic [6:0]  bon;
    logic [6:0]  kill;
    bit          toggle;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // bird 6 is the leftmost field of each concatenation, bird 0 the rightmost
    vecs[0] = '{8'd40,
                {8'd0, 8'd0, 8'd0, 8'd45, 8'd0, 8'd40, 8'd42},
                {7'd0, 7'd0, 7'd0, 7'd30, 7'd0, 7'd30, 7'd30},
                7'b0001001, 7'b0001001, 1'b0};
    vecs[1] = '{8'd2,
                {8'd4, 8'd2, 8'd2, 8'd1, 8'd8, 8'd7, 8'd255},
                {7'd30, 7'd111, 7'd112, 7'd30, 7'd30, 7'd30, 7'd30},
                7'b0111111, 7'b0100010, 1'b1};
    vecs[2] = '{8'd253,
                {8'd0, 8'd0, 8'd0, 8'd0, 8'd254, 8'd253, 8'd0},
                {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd50, 7'd30},
                7'b0000111, 7'b0000111, 1'b0};
    vecs[3] = '{8'd100,
                {8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100},
                {7'd30, 7'd30, 7'd30, 7'd30, 7'd30, 7'd30, 7'd30},
                7'b0000000, 7'b0000000, 1'b0};
    vecs[4] = '{8'd10,
                {8'd15, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                {7'd0, 7'd127, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0},
                7'b1100000, 7'b1000000, 1'b1};

    reset = 1'b1; one_frame = 1'b0; fire = 1'b1; hunter_x = 8'd0;
    bird_x = '0; bird_y = '0; bird_on = '0; grant = 1'b0;
    tick(); tick(); tick();
    check("rst_req", int'(req), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_kill", int'(kill), 0);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);

    // fire held through reset must not start a shot
    reset = 1'b0;
    tick(); tick(); tick();
    check("held_fire_busy", int'(busy), 0);
    fire = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_shot(vecs[i].hx, vecs[i].bx, vecs[i].by, vecs[i].bon, vecs[i].kill, vecs[i].toggle);

    // climb the score to 254 with seven-bird volleys, then saturate
    while (exp_score <= 247)
      run_shot(8'd60, {7{8'd62}}, {7{7'd30}}, 7'h7f, 7'h7f, 1'b0);
    while (exp_score < 254)
      run_shot(8'd60, {7{8'd62}}, {7{7'd30}}, 7'b0000001, 7'b0000001, 1'b0);
    check("score_254", int'(score), 254);
    run_shot(8'd253, {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd254, 8'd0}, {7{7'd20}},
             7'b0000111, 7'b0000111, 1'b0);
    check("score_sat", int'(score), 255);
    run_shot(8'd60, {7{8'd62}}, {7{7'd30}}, 7'h7f, 7'h7f, 1'b0);
    check("score_stays", int'(score), 255);

    // reset mid-DRAW
    hunter_x = 8'd77;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    grant = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("middraw_req", int'(req), 1);
    check("middraw_y", int'(y_out), HY - 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant = 1'b0;
    check("mr_req", int'(req), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_score", int'(score), 0);
    check("mr_kill", int'(kill), 0);
    check("mr_colour", int'(colour), 0);
    tick();
    check("mr_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/laser_shot.md
# laser_shot

Hunter laser controller for the duck-hunt game. It detects a fire press and latches the hunter's column. It then streams the vertical laser pixels to the drawing arbiter ahead of the VGA adapter, tests the laser column against all seven bird positions, and pulses a per-bird kill mask. That mask is consumed upstream of bird enable and draw control. It also holds the laser on screen for a fixed number of frames, erases it, and enforces a cooldown before the next shot.

## Interface
- HUNTER_Y, 7'd112: hunter sprite row; the laser spans rows HUNTER_Y-1 down to 0.
- LASER_FRAMES, 4'd6: frame ticks the laser stays visible; legal range 1..15.
- COOL_FRAMES, 6'd30: frame ticks after erase before the next shot is accepted; legal range 1..63.
- LASER_COLOUR, 3'b010: colour of drawn laser pixels.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- one_frame  in  1  one-cycle 60 Hz frame tick
- fire  in  1  fire button level, active-high (already inverted from KEY)
- hunter_x  in  8  current hunter column
- bird_x  in  56  flattened bird columns; bird i is [8i+7:8i], the head (rightmost) pixel
- bird_y  in  49  flattened bird rows; bird i is [7i+6:7i]
- bird_on  in  7  active-bird mask
- grant  in  1  arbiter has accepted the current pixel this cycle
- req  out  1  pixel valid / request to draw
- x_out  out  8  pixel column
- y_out  out  7  pixel row
- colour  out  3  pixel colour
- kill  out  7  one-cycle hit pulse per bird
- score  out  8  saturating hit count
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, DRAW, HIT_CHECK, HOLD, ERASE, COOLDOWN.
- Fire detection: fire_d registers fire. A press is fire & ~fire_d.
- IDLE → DRAW: taken on a press. On the same edge, shot_x <= hunter_x and y_out <= HUNTER_Y-1.
- Presses in any other state are dropped and are not queued.
- DRAW:
  - Outputs are req=1, x_out=shot_x, colour=LASER_COLOUR.
  - Each cycle with grant=1, y_out decrements.
  - A grant while y_out==0 moves the FSM to HIT_CHECK. Exactly HUNTER_Y pixels are emitted.
  - With grant=0 the pixel outputs hold.
- HIT_CHECK (one cycle), req=0:
  - For each i, diff = bird_x[i] - shot_x, computed mod 256.
  - hit[i] = bird_on[i] & (diff <= 5) & (bird_y[i] < HUNTER_Y).
  - kill = hit during this cycle only.
  - score <= min(255, score + popcount(hit)).
  - Next state is HOLD, with the frame counter cleared.
- HOLD: req=0. The frame counter increments on one_frame. When the LASER_FRAMES-th tick arrives, go to ERASE with y_out <= HUNTER_Y-1.
- ERASE: same stream as DRAW but colour=3'b000. A grant at y_out==0 moves to COOLDOWN with the frame counter cleared.
- COOLDOWN: req=0. After COOL_FRAMES one_frame ticks, go to IDLE.
- grant while req=0 is ignored.
- x_out holds shot_x in every non-IDLE state. colour is 3'b000 whenever the state is not DRAW.

## Timing
- Reset values:
  - State IDLE.
  - req=0, x_out=0, y_out=0, colour=0, kill=0, score=0, busy=0, shot_x=0, counters 0.
  - fire_d is forced to 1, so a button held through reset does not fire.
- Reset mid-shot: return to IDLE on the next edge. Pixels already drawn are not erased by this block. score is cleared.
- Press to first req: 1 cycle, since req is high in the cycle after the press edge.
- DRAW with continuous grant lasts exactly HUNTER_Y cycles. HIT_CHECK follows with kill high for 1 cycle. score updates on the edge that ends HIT_CHECK.
- A one_frame tick on the cycle of entering HOLD or COOLDOWN is not counted. Counting starts the cycle after entry.
- Wrap-around: shot_x=2 with bird_x=255 gives diff=253, which is a miss. shot_x=253 with bird_x=0 gives diff=3, which is a hit.
- bird inputs are sampled only in HIT_CHECK. Changes during DRAW are irrelevant.
- Simultaneous hits on several birds all register, and score adds the full count.

## Test plan
- Reset, fire=1 held, release, press at hunter_x=40 → one shot; 112 pixels (40,111..0) colour 010 under constant grant; busy high.
- Birds 0 and 3 on at bird_x=42 and 45 (y=30), bird 1 off at x=40 → kill=7'b0001001 for one cycle; score 0→2.
- Grant toggled 1,0,1,0 during DRAW → y_out steps only on granted cycles; total still 112 pixels, no duplicate or missing rows.
- After 6 one_frame ticks in HOLD → ERASE streams 112 pixels colour 000 at the same x. Presses during HOLD and COOLDOWN are ignored. A press after 30 COOLDOWN ticks starts a new shot.
- score preset to 254 via shots, then a 3-bird hit → score=255 and stays. Also shot_x=253 with bird_x=0 → hit.
- Reset asserted mid-DRAW → next cycle state IDLE, req=0, score=0, kill=0.
